// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register slave: ID / SCRATCH / CTRL / STATUS bank behind independent
// write (AW/W/B) and read (AR/R) channel state machines. All outputs are registered.
module axi_lite_reg_slave #(
  parameter int unsigned ADDR_W     = 32,
  parameter logic [31:0] ID_VALUE   = 32'hDA7A_0001,
  parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       ctrl_o,
  input  logic [31:0]       status_i
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic addr_oor(input logic [ADDR_W-1:0] a);
    return |a[ADDR_W-1:4];
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    return r;
  endfunction

  // Byte-offset bits carry no meaning in a word-wide register bank.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // ---------------- write channel ----------------
  w_state_t    w_state_q, w_state_d;
  logic        aw_held_q, aw_held_d;
  logic [1:0]  aw_idx_q, aw_idx_d;
  logic        aw_oor_q, aw_oor_d;
  logic        w_held_q, w_held_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] ctrl_q, ctrl_d;

  logic        aw_hs, w_hs, aw_avail, w_avail;
  logic [1:0]  cmt_idx;
  logic        cmt_oor;
  logic [31:0] cmt_data;
  logic [3:0]  cmt_strb;

  assign aw_hs    = s_axi_awvalid && awready_q;
  assign w_hs     = s_axi_wvalid && wready_q;
  assign aw_avail = aw_held_q || aw_hs;
  assign w_avail  = w_held_q || w_hs;
  // Commit uses the live channel when its handshake is on this edge, else the latch.
  assign cmt_idx  = aw_hs ? s_axi_awaddr[3:2]      : aw_idx_q;
  assign cmt_oor  = aw_hs ? addr_oor(s_axi_awaddr) : aw_oor_q;
  assign cmt_data = w_hs  ? s_axi_wdata            : wdata_q;
  assign cmt_strb = w_hs  ? s_axi_wstrb            : wstrb_q;

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    aw_oor_d  = aw_oor_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_idx_d  = s_axi_awaddr[3:2];
          aw_oor_d  = addr_oor(s_axi_awaddr);
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
        end
        if (aw_avail && w_avail) begin
          if (!cmt_oor) begin
            unique case (cmt_idx)
              2'd1:    scratch_d = merge_bytes(scratch_q, cmt_data, cmt_strb);
              2'd2:    ctrl_d    = merge_bytes(ctrl_q, cmt_data, cmt_strb);
              default: ;
            endcase
          end
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = cmt_oor ? RESP_SLVERR : RESP_OKAY;
          w_state_d = W_RESP;
        end else begin
          awready_d = !aw_avail;
          wready_d  = !w_avail;
        end
      end
      W_RESP: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        if (s_axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_oor_q  <= 1'b0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      scratch_q <= '0;
      ctrl_q    <= CTRL_RESET;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_oor_q  <= aw_oor_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // ---------------- read channel ----------------
  r_state_t    r_state_q, r_state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        ar_hs;

  assign ar_hs = s_axi_arvalid && arready_q;

  // Read data comes from the pre-edge register values, so a same-edge write is not visible.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
          if (addr_oor(s_axi_araddr)) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end else begin
            rresp_d = RESP_OKAY;
            unique case (s_axi_araddr[3:2])
              2'd0:    rdata_d = ID_VALUE;
              2'd1:    rdata_d = scratch_q;
              2'd2:    rdata_d = ctrl_q;
              default: rdata_d = status_i;
            endcase
          end
        end
      end
      R_DATA: begin
        arready_d = 1'b0;
        if (s_axi_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign ctrl_o        = ctrl_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: directed vector table, hand-written
// corner sequences, and randomized traffic against a register-map reference model.
module tb_axi_lite_reg_slave;

  localparam logic [31:0] ID_VAL = 32'hDA7A_0001;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [31:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [31:0] ctrl_o;
  logic [31:0] status_i = 32'h0BAD_F00D;

  axi_lite_reg_slave #(
    .ADDR_W    (32),
    .ID_VALUE  (ID_VAL),
    .CTRL_RESET(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .ctrl_o       (ctrl_o),
    .status_i     (status_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: word-indexed register map with per-byte strobes.
  logic [31:0] m_reg [4];

  task automatic m_reset();
    m_reg[0] = ID_VAL;
    m_reg[1] = '0;
    m_reg[2] = '0;
    m_reg[3] = '0;
  endtask

  function automatic logic [1:0] m_write(input logic [31:0] addr, input logic [31:0] data,
                                         input logic [3:0] strb);
    int unsigned word;
    if (addr >= 32'h10) return SLVERR;
    word = addr / 4;
    if (word == 1 || word == 2)
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_reg[word][8*b +: 8] = data[8*b +: 8];
    return OKAY;
  endfunction

  task automatic m_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    if (addr >= 32'h10) begin
      data = '0;
      resp = SLVERR;
    end else begin
      resp = OKAY;
      data = (addr / 4 == 3) ? status_i : m_reg[addr / 4];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int bready_dly,
                           output logic [1:0] resp, output int lat);
    bit aw_done = 1'b0, w_done = 1'b0, aw_p, w_p;
    int cyc = 0;
    logic [1:0] r0;
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      s_axi_awvalid = !aw_done && cyc >= aw_dly;
      s_axi_wvalid  = !w_done && cyc >= w_dly;
      if (aw_done) chk("awready_drops_when_latched", 32'(s_axi_awready), 32'd0);
      if (w_done)  chk("wready_drops_when_latched", 32'(s_axi_wready), 32'd0);
      aw_p = s_axi_awvalid && s_axi_awready;
      w_p  = s_axi_wvalid && s_axi_wready;
      tick();
      if (aw_p) aw_done = 1'b1;
      if (w_p)  w_done = 1'b1;
      cyc++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    chk("aw_w_handshake_timeout", 32'(aw_done && w_done), 32'd1);
    lat = 1;
    while (!s_axi_bvalid && lat < 20) begin
      tick();
      lat++;
    end
    resp = s_axi_bresp;
    r0 = s_axi_bresp;
    for (int i = 0; i < bready_dly; i++) begin
      tick();
      chk("bvalid_held", 32'(s_axi_bvalid), 32'd1);
      chk("bresp_held", 32'(s_axi_bresp), 32'(r0));
      chk("awready_low_in_resp", 32'(s_axi_awready), 32'd0);
      chk("wready_low_in_resp", 32'(s_axi_wready), 32'd0);
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    chk("bvalid_cleared", 32'(s_axi_bvalid), 32'd0);
    chk("awready_back", 32'(s_axi_awready), 32'd1);
    chk("wready_back", 32'(s_axi_wready), 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rready_dly,
                          output logic [31:0] data, output logic [1:0] resp, output int lat);
    bit done = 1'b0, p;
    int cyc = 0;
    s_axi_araddr = addr;
    while (!done && cyc < 50) begin
      s_axi_arvalid = 1'b1;
      p = s_axi_arvalid && s_axi_arready;
      tick();
      if (p) done = 1'b1;
      cyc++;
    end
    s_axi_arvalid = 1'b0;
    chk("ar_handshake_timeout", 32'(done), 32'd1);
    lat = 1;
    while (!s_axi_rvalid && lat < 20) begin
      tick();
      lat++;
    end
    data = s_axi_rdata;
    resp = s_axi_rresp;
    for (int i = 0; i < rready_dly; i++) begin
      tick();
      chk("rvalid_held", 32'(s_axi_rvalid), 32'd1);
      chk("rdata_held", s_axi_rdata, data);
      chk("rresp_held", 32'(s_axi_rresp), 32'(resp));
      chk("arready_low_in_data", 32'(s_axi_arready), 32'd0);
    end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    chk("rvalid_cleared", 32'(s_axi_rvalid), 32'd0);
    chk("arready_back", 32'(s_axi_arready), 32'd1);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic [31:0] exp_ctrl;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp, wresp, exp_resp;
    logic [31:0] rd, exp_rd, old_val;
    int          lat, wlat;

    vecs[0]  = '{1'b0, 32'h00, 32'h0,         4'h0,    0, 0, OKAY,   ID_VAL,        32'h0};
    vecs[1]  = '{1'b1, 32'h04, 32'hAAAA_AAAA, 4'hF,    0, 0, OKAY,   32'h0,         32'h0};
    vecs[2]  = '{1'b0, 32'h04, 32'h0,         4'h0,    0, 0, OKAY,   32'hAAAA_AAAA, 32'h0};
    vecs[3]  = '{1'b1, 32'h08, 32'h1234_5678, 4'b0101, 3, 0, OKAY,   32'h0,         32'h0034_0078};
    vecs[4]  = '{1'b0, 32'h08, 32'h0,         4'h0,    0, 0, OKAY,   32'h0034_0078, 32'h0034_0078};
    vecs[5]  = '{1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF,    0, 1, SLVERR, 32'h0,         32'h0034_0078};
    vecs[6]  = '{1'b0, 32'h24, 32'h0,         4'h0,    0, 0, SLVERR, 32'h0,         32'h0034_0078};
    vecs[7]  = '{1'b0, 32'h04, 32'h0,         4'h0,    0, 0, OKAY,   32'hAAAA_AAAA, 32'h0034_0078};
    vecs[8]  = '{1'b1, 32'h00, 32'h0,         4'hF,    2, 0, OKAY,   32'h0,         32'h0034_0078};
    vecs[9]  = '{1'b0, 32'h01, 32'h0,         4'h0,    0, 0, OKAY,   ID_VAL,        32'h0034_0078};
    vecs[10] = '{1'b1, 32'h06, 32'h1234_0000, 4'b1100, 1, 2, OKAY,   32'h0,         32'h0034_0078};
    vecs[11] = '{1'b0, 32'h07, 32'h0,         4'h0,    0, 0, OKAY,   32'h1234_AAAA, 32'h0034_0078};
    vecs[12] = '{1'b0, 32'h0C, 32'h0,         4'h0,    0, 0, OKAY,   32'h0BAD_F00D, 32'h0034_0078};

    // Reset state
    m_reset();
    repeat (3) tick();
    chk("rst_awready", 32'(s_axi_awready), 32'd0);
    chk("rst_wready", 32'(s_axi_wready), 32'd0);
    chk("rst_arready", 32'(s_axi_arready), 32'd0);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    chk("rst_resp", {28'd0, s_axi_bresp, s_axi_rresp}, 32'd0);
    chk("rst_ctrl", ctrl_o, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_readies", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, 0, resp, lat);
        void'(m_write(vecs[i].addr, vecs[i].data, vecs[i].strb));
        chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
        chk($sformatf("vec%0d_blat", i), 32'(lat), 32'd1);
      end else begin
        axi_read(vecs[i].addr, 0, rd, resp, lat);
        chk($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
        chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        chk($sformatf("vec%0d_rlat", i), 32'(lat), 32'd1);
      end
      chk($sformatf("vec%0d_ctrl", i), ctrl_o, vecs[i].exp_ctrl);
    end

    // Read on the same edge as a write commit to the same register sees the old value
    old_val = m_reg[2];
    fork
      axi_write(32'h08, 32'hCAFE_F00D, 4'hF, 0, 0, 0, wresp, wlat);
      axi_read(32'h08, 0, rd, resp, lat);
    join
    void'(m_write(32'h08, 32'hCAFE_F00D, 4'hF));
    chk("same_edge_rdata_old", rd, old_val);
    chk("same_edge_bresp", 32'(wresp), 32'(OKAY));
    chk("same_edge_ctrl_new", ctrl_o, 32'hCAFE_F00D);

    // Both response channels back-pressured for 5 cycles
    old_val = m_reg[1];
    fork
      axi_write(32'h04, 32'h0BAD_BEEF, 4'hF, 0, 0, 5, wresp, wlat);
      axi_read(32'h04, 5, rd, resp, lat);
    join
    void'(m_write(32'h04, 32'h0BAD_BEEF, 4'hF));
    chk("bp_rdata", rd, old_val);
    chk("bp_bresp", 32'(wresp), 32'(OKAY));
    axi_write(32'h04, 32'h0000_1111, 4'b0011, 0, 0, 0, resp, lat);
    void'(m_write(32'h04, 32'h0000_1111, 4'b0011));
    axi_read(32'h04, 0, rd, resp, lat);
    chk("bp_after_rdata", rd, 32'h0BAD_1111);

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      a = ($urandom_range(0, 9) < 7) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(16, 255));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      status_i = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        exp_resp = m_write(a, d, s);
        axi_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)), resp, lat);
        chk($sformatf("rnd%0d_bresp_a%0h", n, a), 32'(resp), 32'(exp_resp));
        chk($sformatf("rnd%0d_blat", n), 32'(lat), 32'd1);
      end else begin
        m_read(a, exp_rd, exp_resp);
        axi_read(a, int'($urandom_range(0, 2)), rd, resp, lat);
        chk($sformatf("rnd%0d_rresp_a%0h", n, a), 32'(resp), 32'(exp_resp));
        chk($sformatf("rnd%0d_rdata_a%0h", n, a), rd, exp_rd);
      end
      chk($sformatf("rnd%0d_ctrl", n), ctrl_o, m_reg[2]);
    end

    // Reset while a write response is pending
    s_axi_awaddr = 32'h04; s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("mid_rst_bvalid_before", 32'(s_axi_bvalid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_bvalid_async", 32'(s_axi_bvalid), 32'd0);
    chk("mid_rst_ctrl_async", ctrl_o, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    m_reset();
    tick();
    tick();
    chk("mid_rst_no_response", 32'(s_axi_bvalid), 32'd0);
    axi_read(32'h04, 0, rd, resp, lat);
    chk("mid_rst_scratch", rd, 32'd0);
    chk("mid_rst_scratch_resp", 32'(resp), 32'(OKAY));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
